// File: rtl/mips_result_checker.sv
// mips_result_checker
//
// Self-contained regression harness for the MIPS pipeline core. A start
// request holds the core in reset, lets it run for a bounded number of cycles
// (or until it reports halt), then freezes it and reads back up to NUM_CHECKS
// data-memory words, comparing each against an expected value. The verdict is
// held on the outputs, so FPGA regression runs need no simulator.
//
// Ports
//   clk_i          single clock, rising edge
//   rst_i          synchronous active-high reset, wins in every state
//   start_i        begin a run (accepted only in IDLE or DONE)
//   chk_en_i       bit i enables check i
//   chk_addr_i     byte address of check i at [i*ADDR_W +: ADDR_W]
//   chk_data_i     expected word of check i at [i*DATA_W +: DATA_W]
//   cpu_halt_i     core reports program end (honoured only in RUN)
//   cpu_n_rst_o    active-low reset to the core, high only in RUN
//   mem_rd_en_o    data-memory read strobe
//   mem_rd_addr_o  word index of the current check
//   mem_rd_data_i  read data, valid one cycle after mem_rd_en_o
//   busy_o         run in progress (RESET through the last CMP)
//   done_o         results valid
//   pass_o         all enabled checks matched (qualified by done_o)
//   fail_vec_o     bit i set when check i mismatched
//   fail_idx_o     lowest failing check index
//   fail_actual_o  data read for fail_idx_o
//   run_cycles_o   cycles the core actually spent in RUN

module mips_result_checker #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int NUM_CHECKS = 4,
  parameter int RST_CYCLES = 2,
  parameter int RUN_CYCLES = 100,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [NUM_CHECKS-1:0]        chk_en_i,
  input  logic [NUM_CHECKS*ADDR_W-1:0] chk_addr_i,
  input  logic [NUM_CHECKS*DATA_W-1:0] chk_data_i,
  input  logic                         cpu_halt_i,
  output logic                         cpu_n_rst_o,
  output logic                         mem_rd_en_o,
  output logic [ADDR_W-3:0]            mem_rd_addr_o,
  input  logic [DATA_W-1:0]            mem_rd_data_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         pass_o,
  output logic [NUM_CHECKS-1:0]        fail_vec_o,
  output logic [IDX_W-1:0]             fail_idx_o,
  output logic [DATA_W-1:0]            fail_actual_o,
  output logic [CNT_W-1:0]             run_cycles_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_READ,
    S_CMP,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHECKS-1:0]   failVec_q, failVec_d;
  logic [IDX_W-1:0]        failIdx_q, failIdx_d;
  logic [DATA_W-1:0]       failActual_q, failActual_d;
  logic [CNT_W-1:0]        runCycles_q, runCycles_d;

  logic [ADDR_W-3:0]       wordAddr [NUM_CHECKS];
  logic [DATA_W-1:0]       expData  [NUM_CHECKS];
  logic                    unusedByteOffset;
  logic                    mismatch;

  // Split the flat check buses into per-check words. The two byte-offset
  // bits of each address are dropped so a misaligned address checks the
  // word that contains it.
  always_comb begin
    unusedByteOffset = 1'b0;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      wordAddr[i]      = chk_addr_i[i*ADDR_W+2 +: ADDR_W-2];
      expData[i]       = chk_data_i[i*DATA_W +: DATA_W];
      unusedByteOffset = unusedByteOffset ^ (^chk_addr_i[i*ADDR_W +: 2]);
    end
  end

  // Disabled checks can never fail; their read data is whatever the memory
  // port happens to hold and is ignored.
  assign mismatch = chk_en_i[idx_q] && (mem_rd_data_i != expData[idx_q]);

  // Next-state logic. The shared counter times RESET and then RUN; every
  // check takes one READ and one CMP cycle whether enabled or not, so total
  // latency depends only on the parameters and on when halt arrives.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    failVec_d    = failVec_q;
    failIdx_d    = failIdx_q;
    failActual_d = failActual_q;
    runCycles_d  = runCycles_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d      = S_RESET;
          cnt_d        = '0;
          idx_d        = '0;
          failVec_d    = '0;
          failIdx_d    = '0;
          failActual_d = '0;
        end
      end

      S_RESET: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // cnt_q holds the number of completed RUN cycles, so the cycle being
      // exited is number cnt_q+1.
      S_RUN: begin
        if (cpu_halt_i || (cnt_q == CNT_W'(RUN_CYCLES - 1))) begin
          state_d     = S_READ;
          runCycles_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_READ: begin
        state_d = S_CMP;
      end

      // Only the first mismatch of a run updates the index/actual capture.
      S_CMP: begin
        if (mismatch) begin
          failVec_d[idx_q] = 1'b1;
          if (failVec_q == '0) begin
            failIdx_d    = idx_q;
            failActual_d = mem_rd_data_i;
          end
        end
        if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset returns everything to the idle,
  // empty-result condition and abandons any run in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      failVec_q    <= '0;
      failIdx_q    <= '0;
      failActual_q <= '0;
      runCycles_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      failVec_q    <= failVec_d;
      failIdx_q    <= failIdx_d;
      failActual_q <= failActual_d;
      runCycles_q  <= runCycles_d;
    end
  end

  // Outputs are decoded from the registered state, so the core is released
  // only during RUN and is frozen while its memory is read back.
  assign cpu_n_rst_o   = (state_q == S_RUN);
  assign mem_rd_en_o   = (state_q == S_READ) && chk_en_i[idx_q];
  assign mem_rd_addr_o = (state_q == S_READ) ? wordAddr[idx_q] : '0;
  assign busy_o        = (state_q == S_RESET) || (state_q == S_RUN) ||
                         (state_q == S_READ)  || (state_q == S_CMP);
  assign done_o        = (state_q == S_DONE);
  assign pass_o        = (state_q == S_DONE) && (failVec_q == '0);
  assign fail_vec_o    = failVec_q;
  assign fail_idx_o    = failIdx_q;
  assign fail_actual_o = failActual_q;
  assign run_cycles_o  = runCycles_q;

endmodule

// File: tb/tb_mips_result_checker.sv
// Testbench for mips_result_checker: directed test-plan runs followed by
// randomized runs, each checked against a behavioural reference model that
// derives verdicts and cycle positions from the checker's rules.
module tb_mips_result_checker;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int NUM_CHECKS = 4;
  localparam int RST_CYCLES = 2;
  localparam int RUN_CYCLES = 100;
  localparam int CNT_W      = 16;
  localparam int IDX_W      = 2;
  localparam int MEM_WORDS  = 64;
  localparam int MAX_CYC    = 400;

  logic                         clk;
  logic                         rst;
  logic                         startIn;
  logic [NUM_CHECKS-1:0]        chkEn;
  logic [NUM_CHECKS*ADDR_W-1:0] chkAddr;
  logic [NUM_CHECKS*DATA_W-1:0] chkData;
  logic                         cpuHalt;
  logic                         cpuNRst;
  logic                         memRdEn;
  logic [ADDR_W-3:0]            memRdAddr;
  logic [DATA_W-1:0]            memRdData;
  logic                         busy;
  logic                         done;
  logic                         pass;
  logic [NUM_CHECKS-1:0]        failVec;
  logic [IDX_W-1:0]             failIdx;
  logic [DATA_W-1:0]            failActual;
  logic [CNT_W-1:0]             runCycles;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  int checks = 0;
  int errors = 0;

  int doneCycle;
  int nrstCount;
  int nrstFirst;
  int nrstLast;
  bit busyBad;
  int rdCycles[$];
  int rdAddrs[$];

  mips_result_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CHECKS(NUM_CHECKS),
    .RST_CYCLES(RST_CYCLES), .RUN_CYCLES(RUN_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(startIn),
    .chk_en_i(chkEn), .chk_addr_i(chkAddr), .chk_data_i(chkData),
    .cpu_halt_i(cpuHalt), .cpu_n_rst_o(cpuNRst),
    .mem_rd_en_o(memRdEn), .mem_rd_addr_o(memRdAddr), .mem_rd_data_i(memRdData),
    .busy_o(busy), .done_o(done), .pass_o(pass),
    .fail_vec_o(failVec), .fail_idx_o(failIdx), .fail_actual_o(failActual),
    .run_cycles_o(runCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory with one cycle of read latency; outside a read the port
  // carries junk so data sampled at the wrong time shows up as a mismatch.
  always @(posedge clk) begin
    if (memRdEn) memRdData <= mem[memRdAddr[5:0]];
    else         memRdData <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic setCheck(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chkAddr[i*ADDR_W +: ADDR_W] = a;
    chkData[i*DATA_W +: DATA_W] = d;
  endtask

  function automatic int wordOf(input int i);
    logic [ADDR_W-1:0] a;
    a = chkAddr[i*ADDR_W +: ADDR_W];
    return int'(a) / 4;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "/cpu_n_rst"},   cpuNRst,    0);
    checkOutput({tag, "/mem_rd_en"},   memRdEn,    0);
    checkOutput({tag, "/mem_rd_addr"}, memRdAddr,  0);
    checkOutput({tag, "/busy"},        busy,       0);
    checkOutput({tag, "/done"},        done,       0);
    checkOutput({tag, "/pass"},        pass,       0);
    checkOutput({tag, "/fail_vec"},    failVec,    0);
    checkOutput({tag, "/fail_idx"},    failIdx,    0);
    checkOutput({tag, "/fail_actual"}, failActual, 0);
    checkOutput({tag, "/run_cycles"},  runCycles,  0);
  endtask

  // Launches one run from IDLE/DONE and observes it cycle by cycle. Cycle 1
  // is the first cycle after the edge that samples start. haltAt>0 raises
  // halt in that RUN cycle; haltEarly also raises it through RESET, where it
  // must be ignored; glitchStart pulses start in RUN and in the first CMP.
  task automatic applyStimulus(input int haltAt, input bit haltEarly, input bit glitchStart);
    int cyc;
    int runLen;
    runLen    = (haltAt > 0) ? haltAt : RUN_CYCLES;
    doneCycle = -1;
    nrstCount = 0;
    nrstFirst = -1;
    nrstLast  = -1;
    busyBad   = 1'b0;
    rdCycles.delete();
    rdAddrs.delete();
    @(negedge clk);
    startIn = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (cyc <= MAX_CYC && doneCycle < 0) begin
      cpuHalt = ((haltAt > 0) && (cyc == RST_CYCLES + haltAt)) ||
                (haltEarly && (cyc <= RST_CYCLES));
      startIn = glitchStart && ((cyc == RST_CYCLES + 5) || (cyc == RST_CYCLES + runLen + 2));
      if (done) begin
        doneCycle = cyc;
      end else begin
        if (!busy) busyBad = 1'b1;
        if (cpuNRst) begin
          nrstCount++;
          if (nrstFirst < 0) nrstFirst = cyc;
          nrstLast = cyc;
        end
        if (memRdEn) begin
          rdCycles.push_back(cyc);
          rdAddrs.push_back(int'(memRdAddr));
        end
      end
      @(negedge clk);
      cyc++;
    end
    cpuHalt = 1'b0;
    startIn = 1'b0;
    if (doneCycle < 0) checkOutput("done_timeout", 0, 1);
  endtask

  // Reference model: verdicts follow from comparing each enabled expected
  // word against memory; timing follows from RESET + RUN + two cycles per
  // check, with check i read in the (2i+1)-th cycle after RUN.
  task automatic checkRun(input int haltAt, input string name);
    int runLen;
    int expDone;
    logic [NUM_CHECKS-1:0] expFv;
    int expIdx;
    logic [DATA_W-1:0] expActual;
    int expCyc[$];
    int expAddr[$];
    runLen    = (haltAt > 0) ? haltAt : RUN_CYCLES;
    expDone   = 1 + RST_CYCLES + runLen + 2 * NUM_CHECKS;
    expFv     = '0;
    expIdx    = 0;
    expActual = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (chkEn[i] && (mem[wordOf(i)] != chkData[i*DATA_W +: DATA_W])) begin
        expFv[i]  = 1'b1;
        expIdx    = i;
        expActual = mem[wordOf(i)];
      end
      if (chkEn[i]) begin
        expCyc.push_front(RST_CYCLES + runLen + 1 + 2 * i);
        expAddr.push_front(wordOf(i));
      end
    end
    checkOutput({name, "/done_cycle"},  doneCycle,  expDone);
    checkOutput({name, "/pass"},        pass,       (expFv == '0));
    checkOutput({name, "/fail_vec"},    failVec,    expFv);
    checkOutput({name, "/fail_idx"},    failIdx,    expIdx);
    checkOutput({name, "/fail_actual"}, failActual, expActual);
    checkOutput({name, "/run_cycles"},  runCycles,  runLen);
    checkOutput({name, "/busy_in_run"}, busyBad,    0);
    checkOutput({name, "/busy_done"},   busy,       0);
    checkOutput({name, "/nrst_done"},   cpuNRst,    0);
    checkOutput({name, "/nrst_count"},  nrstCount,  runLen);
    checkOutput({name, "/nrst_first"},  nrstFirst,  RST_CYCLES + 1);
    checkOutput({name, "/nrst_last"},   nrstLast,   RST_CYCLES + runLen);
    checkOutput({name, "/rd_pulses"},   rdCycles.size(), expCyc.size());
    for (int j = 0; j < expCyc.size() && j < rdCycles.size(); j++) begin
      checkOutput($sformatf("%s/rd%0d_cycle", name, j), rdCycles[j], expCyc[j]);
      checkOutput($sformatf("%s/rd%0d_addr", name, j),  rdAddrs[j],  expAddr[j]);
    end
  endtask

  initial begin
    int haltAt;
    bit doneSeen;
    rst       = 1'b1;
    startIn   = 1'b0;
    cpuHalt   = 1'b0;
    chkEn     = '0;
    chkAddr   = '0;
    chkData   = '0;
    memRdData = '0;
    for (int w = 0; w < MEM_WORDS; w++) mem[w] = $urandom;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkIdleOutputs("reset");

    // Program stored 21 at byte address 4; single enabled check, no halt.
    mem[1] = 32'd21;
    for (int i = 1; i < NUM_CHECKS; i++) setCheck(i, 16'(8 * i), $urandom);
    setCheck(0, 16'd4, 32'd21);
    chkEn = 4'b0001;
    applyStimulus(0, 1'b0, 1'b0);
    checkRun(0, "store21");
    checkOutput("store21/pass_const", pass, 1);

    // Wrong expected value; results then hold while DONE idles.
    mem[1] = 32'd7;
    setCheck(0, 16'd4, 32'h8f0f_f00b);
    applyStimulus(0, 1'b0, 1'b0);
    checkRun(0, "mismatch0");
    repeat (5) @(negedge clk);
    checkOutput("mismatch0/done_hold",   done,       1);
    checkOutput("mismatch0/fail_vec_c",  failVec,    4'b0001);
    checkOutput("mismatch0/fail_actual", failActual, 7);

    // All four enabled, misaligned addresses, mismatches at checks 1 and 3.
    mem[2] = 32'h1111_2222; mem[3] = 32'h3333_4444; mem[5] = 32'h5555_6666;
    setCheck(0, 16'd9,  32'h1111_2222);
    setCheck(1, 16'd12, 32'h3333_4445);
    setCheck(2, 16'd22, 32'h5555_6666);
    setCheck(3, 16'd7,  32'h0000_0000);
    mem[1] = 32'hdead_beef;
    chkEn = 4'b1111;
    applyStimulus(0, 1'b0, 1'b0);
    checkRun(0, "four");
    checkOutput("four/fail_vec_c", failVec, 4'b1010);
    checkOutput("four/fail_idx_c", failIdx, 1);

    // Halt in RUN cycle 37, with halt also held through RESET.
    applyStimulus(37, 1'b1, 1'b0);
    checkRun(37, "halt37");
    checkOutput("halt37/done_c", doneCycle, 48);

    // No checks enabled.
    chkEn = 4'b0000;
    applyStimulus(0, 1'b0, 1'b0);
    checkRun(0, "none");
    checkOutput("none/done_c", doneCycle, 111);

    // Reset mid-RUN abandons the run; a later run ignores stray starts.
    chkEn = 4'b0110;
    @(negedge clk);
    startIn = 1'b1;
    @(negedge clk);
    startIn = 1'b0;
    repeat (RST_CYCLES + 9) @(negedge clk);
    checkOutput("abort/in_run", cpuNRst, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleOutputs("abort");
    doneSeen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (done) doneSeen = 1'b1;
    end
    checkOutput("abort/no_done", doneSeen, 0);
    applyStimulus(0, 1'b0, 1'b1);
    checkRun(0, "restart");

    // Randomized runs.
    for (int r = 0; r < 8; r++) begin
      for (int w = 0; w < MEM_WORDS; w++) mem[w] = $urandom;
      chkEn = 4'($urandom);
      for (int i = 0; i < NUM_CHECKS; i++) begin
        logic [ADDR_W-1:0] a;
        a = 16'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) setCheck(i, a, mem[int'(a) / 4]);
        else setCheck(i, a, mem[int'(a) / 4] ^ ($urandom | 32'd1));
      end
      haltAt = ($urandom_range(0, 1) == 1) ? $urandom_range(1, RUN_CYCLES - 1) : 0;
      applyStimulus(haltAt, 1'($urandom), 1'b0);
      checkRun(haltAt, $sformatf("rand%0d", r));
    end

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
